// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-bundle pipeline: bundle field layout and default width.
package ctrl_pipe_pkg;

    localparam int BIT_MEMTOREG   = 0;
    localparam int BIT_MEMWRITE   = 1;
    localparam int BIT_ALUSRC     = 2;
    localparam int BIT_REGDST     = 3;
    localparam int BIT_REGWRITE   = 4;
    localparam int BIT_ALUCTRL_LO = 5;
    localparam int ALUCTRL_W      = 5;
    localparam int BIT_ALUCTRL_HI = BIT_ALUCTRL_LO + ALUCTRL_W - 1;
    localparam int BIT_HILOWRITE  = 10;
    localparam int BIT_HILOREAD   = 11;
    localparam int BIT_HILOSRC    = 12;
    localparam int BIT_MEMREAD    = 13;
    localparam int BIT_JALR       = 14;
    localparam int BIT_RAWRITE    = 15;
    localparam int BIT_CP0WE      = 16;
    localparam int BIT_CP0READ    = 17;
    localparam int BIT_ERET       = 18;

    // The eret flag is the top field, so the bundle width follows from it.
    localparam int CW_WIDTH = BIT_ERET + 1;

    localparam int DEF_STAGES = 3;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline stage register: valid bit plus control bundle, with kill > hold > bubble > advance.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = CW_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             hold,
    input  logic             bubble,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_bundle,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_bundle
);

    logic             r_valid;
    logic [WIDTH-1:0] r_bundle;

    // An invalid stage always carries an all-zero bundle, so consumers need no gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (kill) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (hold) begin
            r_valid  <= r_valid;
            r_bundle <= r_bundle;
        end else if (bubble) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else begin
            r_valid  <= d_valid;
            r_bundle <= d_valid ? d_bundle : '0;
        end
    end

    assign q_valid  = r_valid;
    assign q_bundle = r_bundle;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from decode through STAGES stages with stall back-propagation,
// per-stage and exception flush, and saturating bubble/flush event counters.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH  = CW_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_bundle,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    except_flush,
    input  logic                    cnt_clr,
    output logic                    stall_up,
    output logic [STAGES-1:0]       out_valid,
    output logic [STAGES*WIDTH-1:0] out_bundle,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    logic [STAGES-1:0] w_es;
    logic [STAGES-1:0] w_kill;
    logic [STAGES-1:0] w_bubble;
    logic              w_bubble_ev;
    logic              w_flush_ev;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    // A stall anywhere downstream freezes every stage upstream of it.
    always_comb begin
        w_es = '0;
        w_es[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_es[k] = stall[k] | w_es[k+1];
        end
    end

    assign stall_up = w_es[0];
    assign w_kill   = flush | {STAGES{except_flush}};

    always_comb begin
        w_bubble = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_bubble[k] = w_es[k-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_first
                ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .kill     (w_kill[g]),
                    .hold     (w_es[g]),
                    .bubble   (w_bubble[g]),
                    .d_valid  (in_valid),
                    .d_bundle (in_bundle),
                    .q_valid  (out_valid[g]),
                    .q_bundle (out_bundle[g*WIDTH +: WIDTH])
                );
            end else begin : g_rest
                ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .kill     (w_kill[g]),
                    .hold     (w_es[g]),
                    .bubble   (w_bubble[g]),
                    .d_valid  (out_valid[g-1]),
                    .d_bundle (out_bundle[(g-1)*WIDTH +: WIDTH]),
                    .q_valid  (out_valid[g]),
                    .q_bundle (out_bundle[g*WIDTH +: WIDTH])
                );
            end
        end
    endgenerate

    // Only bubbles that displace a real instruction and kills of valid stages are events.
    always_comb begin
        w_bubble_ev = 1'b0;
        w_flush_ev  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (w_kill[k] && out_valid[k]) begin
                w_flush_ev = 1'b1;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (!w_kill[k] && !w_es[k] && w_bubble[k] && out_valid[k-1]) begin
                w_bubble_ev = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (cnt_clr) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bubble_ev && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: driver updates a behavioural model and queues expectations,
// a negedge monitor pops and compares against the DUT.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int W   = CW_WIDTH;
    localparam int S   = 3;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_bundle = '0;
    logic [S-1:0]   stall = '0;
    logic [S-1:0]   flush = '0;
    logic           except_flush = 1'b0;
    logic           cnt_clr = 1'b0;
    logic           stall_up;
    logic [S-1:0]   out_valid;
    logic [S*W-1:0] out_bundle;
    logic [CW-1:0]  bubble_cnt;
    logic [CW-1:0]  flush_cnt;

    ctrl_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .in_valid     (in_valid),
        .in_bundle    (in_bundle),
        .stall        (stall),
        .flush        (flush),
        .except_flush (except_flush),
        .cnt_clr      (cnt_clr),
        .stall_up     (stall_up),
        .out_valid    (out_valid),
        .out_bundle   (out_bundle),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [S-1:0]   v;
        logic [S*W-1:0] b;
        logic [CW-1:0]  bc;
        logic [CW-1:0]  fc;
        logic           su;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic         m_v[S];
    logic [W-1:0] m_b[S];
    int           m_bc;
    int           m_fc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_valid",  64'(out_valid),  64'(e.v));
            chk("out_bundle", 64'(out_bundle), 64'(e.b));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
            chk("flush_cnt",  64'(flush_cnt),  64'(e.fc));
            chk("stall_up",   64'(stall_up),   64'(e.su));
        end
    end

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            m_v[k] = 1'b0;
            m_b[k] = '0;
        end
        m_bc = 0;
        m_fc = 0;
    endtask

    // Expected register contents for the current cycle; stall_up is any stall request at all.
    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < S; k++) begin
            e.v[k] = m_v[k];
            e.b[k*W +: W] = m_b[k];
        end
        e.bc = m_bc[CW-1:0];
        e.fc = m_fc[CW-1:0];
        e.su = (stall != '0);
        sb.push_back(e);
    endtask

    task automatic model_step();
        logic         es[S];
        logic         nv[S];
        logic [W-1:0] nb[S];
        logic         bev;
        logic         fev;
        bev = 1'b0;
        fev = 1'b0;
        for (int k = 0; k < S; k++) begin
            es[k] = ((stall >> k) != '0);
        end
        for (int k = 0; k < S; k++) begin
            if (except_flush || flush[k]) begin
                if (m_v[k]) fev = 1'b1;
                nv[k] = 1'b0;
                nb[k] = '0;
            end else if (es[k]) begin
                nv[k] = m_v[k];
                nb[k] = m_b[k];
            end else if (k > 0 && es[k-1]) begin
                if (m_v[k-1]) bev = 1'b1;
                nv[k] = 1'b0;
                nb[k] = '0;
            end else if (k == 0) begin
                nv[k] = in_valid;
                nb[k] = in_valid ? in_bundle : '0;
            end else begin
                nv[k] = m_v[k-1];
                nb[k] = m_b[k-1];
            end
        end
        for (int k = 0; k < S; k++) begin
            m_v[k] = nv[k];
            m_b[k] = nb[k];
        end
        if (cnt_clr) begin
            m_bc = 0;
            m_fc = 0;
        end else begin
            if (bev && m_bc < MAXC) m_bc++;
            if (fev && m_fc < MAXC) m_fc++;
        end
    endtask

    // Called just after a rising edge: drive this cycle's inputs, queue expectation, clock the model.
    task automatic cycle(input logic iv, input logic [W-1:0] ib, input logic [S-1:0] st,
                         input logic [S-1:0] fl, input logic ex, input logic clr);
        in_valid     = iv;
        in_bundle    = ib;
        stall        = st;
        flush        = fl;
        except_flush = ex;
        cnt_clr      = clr;
        push_exp();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        model_reset();
        push_exp();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state, then streaming 1,2,3
        cycle(1'b1, 19'h1, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h2, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h3, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 19'h0, 3'b000, 3'b000, 1'b0, 1'b0);

        // back-propagated stall: A in stage 1, B in stage 0, stall stage 1 for two cycles
        cycle(1'b1, 19'h0A, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h0B, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h0C, 3'b010, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h0C, 3'b010, 3'b000, 1'b0, 1'b0);
        cycle(1'b0, 19'h0,  3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b0, 19'h0,  3'b000, 3'b000, 1'b0, 1'b0);

        // flush over stall on stage 0
        cycle(1'b1, 19'h7FFFF, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b0, 19'h0,     3'b001, 3'b001, 1'b0, 1'b0);
        cycle(1'b0, 19'h0,     3'b000, 3'b000, 1'b0, 1'b0);

        // exception with every stage valid and a live incoming bundle
        cycle(1'b1, 19'h11, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h22, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h33, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h44, 3'b000, 3'b000, 1'b1, 1'b0);
        cycle(1'b0, 19'h0,  3'b000, 3'b000, 1'b0, 1'b0);

        // saturation: stall stage 0 holding a valid bundle -> bubble event every cycle
        cycle(1'b1, 19'h55, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 19'h66, 3'b001, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h66, 3'b001, 3'b000, 1'b0, 1'b1);
        cycle(1'b0, 19'h0,  3'b000, 3'b000, 1'b0, 1'b0);

        // reset in the middle of a loaded pipe
        cycle(1'b1, 19'h00011, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h00022, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h00033, 3'b000, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 19'h00044, 3'b000, 3'b000, 1'b0, 1'b0);
        mid_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [S-1:0] st;
            logic [S-1:0] fl;
            st = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
            fl = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
            if (i == 200) mid_reset();
            cycle(1'($urandom), W'($urandom), st, fl,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
        end
        cycle(1'b0, 19'h0, 3'b000, 3'b000, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised control-bundle pipeline carrying decoded control words from decode through STAGES downstream pipeline stages (E/M/W for STAGES=3). It generalises the fixed E/M/W control registers:
- configurable width and depth
- per-stage valid bits
- per-stage flush
- automatic upstream stall back-propagation with bubble insertion
- global exception flush
- saturating bubble/flush event counters for performance debug

Instantiated once inside the controller, between the decoders and the datapath control inputs.

Parameters:
WIDTH, 19, bits in one control bundle
STAGES, 3, number of pipeline stages (>=2); stage 0 = E
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  decode stage holds a real instruction
in_bundle  in  WIDTH  decoded control bundle from decode
stall  in  STAGES  raw per-stage stall request from hazard unit, bit k = stage k
flush  in  STAGES  per-stage flush, bit k = stage k
except_flush  in  1  exception/eret: kill all stages and the incoming bundle
cnt_clr  in  1  synchronous clear of both counters
stall_up  out  1  effective stall of stage 0; decode/fetch must hold
out_valid  out  STAGES  per-stage valid
out_bundle  out  STAGES*WIDTH  stage k bundle at bits [k*WIDTH +: WIDTH]
bubble_cnt  out  CNT_W  saturating count of cycles in which >=1 bubble was inserted
flush_cnt  out  CNT_W  saturating count of cycles in which >=1 valid stage was killed

Behaviour:
- Reset (rst=0, async): all out_valid=0, all out_bundle=0, both counters=0. This takes effect immediately, mid-operation included. Release is synchronous to clk.
- Effective stall: es[k] = OR(stall[k..STAGES-1]). Stall propagates toward stage 0. stall_up = es[0] (combinational).
- Per-stage update, priority highest first, for each stage k on the rising edge:
  1. except_flush=1 or flush[k]=1: valid<=0, bundle<=0. Flush dominates stall.
  2. es[k]=1: hold valid and bundle.
  3. k>0 and es[k-1]=1: bubble; valid<=0, bundle<=0.
  4. Otherwise advance:
     - stage 0 loads in_valid and (in_valid ? in_bundle : 0)
     - stage k loads stage k-1's valid/bundle
- Invariant: out_valid[k]=0 implies bundle k = 0. Downstream write enables therefore need no extra gating.
- Latency: an unstalled bundle presented in cycle t appears at stage k after the edge ending cycle t+k, i.e. 1 cycle to stage 0 and STAGES cycles to the last stage.
- Simultaneous flush[k] and stall[k]: stage k zeroed. es[k] still stalls upstream stages for that cycle.
- except_flush with es[0]=1: everything zeroed anyway. The decode-side holding instruction is discarded by the fetch/decode flush, not by this block.
- Bubble event: any stage takes rule 3 while the source stage k-1 holds valid=1. An empty bubble behind an invalid stage does not count.
- Flush event: any stage with valid=1 is zeroed by rule 1.
- Counters:
  - increment by 1 per event cycle, saturate at all-ones
  - cnt_clr has priority over an increment in the same cycle; the result is 0
- No combinational path from in_bundle to outputs. stall_up depends only on stall.

Decomposition:
- Shared package ctrl_pipe_pkg:
  - localparams for bundle field bit positions (memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[4:0], hilo*, memread, jalr, rawrite, cp0we, cp0read, eret)
  - default WIDTH derived from them
- Sub-module ctrl_pipe_stage: one valid+bundle register implementing rules 1–4 with inputs kill, hold, bubble, d_valid, d_bundle.
- Top generates STAGES instances plus the es chain and counters.

Test Plan:
- Reset mid-stream: stages loaded with 0x00011/0x00022/0x00033, drive rst=0 between edges -> out_valid=000 and bundles/counters 0 immediately, without waiting for clk.
- Streaming: in_valid=1 with bundles 0x1, 0x2, 0x3 on consecutive cycles, no stalls -> stage 2 shows 0x1, 0x2, 0x3 on cycles 3, 4, 5, each with out_valid[2]=1.
- Back-propagated stall:
  - set up: A=0x0A in stage 1, B=0x0B in stage 0; drive stall=3'b010 for 2 cycles
  - stage 0 and stage 1 hold B and A; stall_up=1
  - stage 2 receives two bubbles (valid 0, bundle 0); bubble_cnt=2
  - release stall -> A reaches stage 2 on the next edge
- Flush over stall: stage 0 valid with 0x7FFFF, flush=001 and stall=001 in the same cycle -> out_valid[0]=0, bundle 0, flush_cnt=1, stall_up=1 during that cycle.
- Exception: all stages valid, in_valid=1, except_flush=1 -> next cycle out_valid=000, incoming bundle not captured, flush_cnt increments by exactly 1.
- Saturation, CNT_W=4: 20 consecutive bubble-event cycles -> bubble_cnt=15 (held). Then cnt_clr=1 together with another bubble event -> bubble_cnt=0.
